// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the credit-based NoC link receiver.
// Flit/dest widths are fixed here so the stored entry layout is one definition.
package noc_link_pkg;

  localparam int FLIT_WIDTH  = 128;
  localparam int TID_WIDTH   = 2;
  localparam int TDEST_WIDTH = 4;
  localparam int DEST_WIDTH  = TDEST_WIDTH + TID_WIDTH;

  typedef enum logic {HEAD, BODY} rx_state_t;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } flit_entry_t;

  // dest is packed as {tid, tdest}
  function automatic logic [TID_WIDTH-1:0] get_tid(input logic [DEST_WIDTH-1:0] dest);
    return dest[DEST_WIDTH-1:TDEST_WIDTH];
  endfunction

  function automatic logic [TDEST_WIDTH-1:0] get_tdest(input logic [DEST_WIDTH-1:0] dest);
    return dest[TDEST_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Circular flit buffer of DEPTH entries (any depth >= 1) with a fall-through head.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module noc_flit_fifo
  import noc_link_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  flit_entry_t      wdata_i,
  output flit_entry_t      rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  flit_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/noc_link_rx.sv
// Credit-based NoC link receiver presenting buffered flits as an AXI-Stream master.
// Define NOC_LINK_RX_CHECK_EN to build the sticky overflow / dest-change error flags.
module noc_link_rx
  import noc_link_pkg::*;
#(
  parameter int BUFFER_DEPTH  = 2,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     clk_noc,
  input  logic                     rst_n,
  input  logic [FLIT_WIDTH-1:0]    data_in,
  input  logic [DEST_WIDTH-1:0]    dest_in,
  input  logic                     is_tail_in,
  input  logic                     send_in,
  output logic                     credit_out,
  output logic                     axis_out_tvalid,
  input  logic                     axis_out_tready,
  output logic [FLIT_WIDTH-1:0]    axis_out_tdata,
  output logic                     axis_out_tlast,
  output logic [TID_WIDTH-1:0]     axis_out_tid,
  output logic [TDEST_WIDTH-1:0]   axis_out_tdest,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count,
  output logic                     err_overflow,
  output logic                     err_dest_change
);

  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

  flit_entry_t              wr_entry, head;
  logic                     fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0]         unused_count;
  logic                     credit_q;
  rx_state_t                state_q, state_d;
  logic                     pkt_inc;
  logic [PKT_CNT_WIDTH-1:0] pkt_count_q;

  assign wr_entry = '{data: data_in, dest: dest_in, is_tail: is_tail_in};

  noc_flit_fifo #(.DEPTH(BUFFER_DEPTH)) u_fifo (
    .clk_i   (clk_noc),
    .rst_ni  (rst_n),
    .push_i  (send_in),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_count)
  );

  assign axis_out_tvalid = !fifo_empty;
  assign pop             = axis_out_tvalid && axis_out_tready;
  assign axis_out_tdata  = head.data;
  assign axis_out_tlast  = head.is_tail;
  assign axis_out_tid    = get_tid(head.dest);
  assign axis_out_tdest  = get_tdest(head.dest);

  // Framing only moves when a beat is actually consumed downstream.
  always_comb begin
    state_d = state_q;
    pkt_inc = 1'b0;
    if (pop) begin
      case (state_q)
        HEAD: begin
          if (head.is_tail) pkt_inc = 1'b1;
          else              state_d = BODY;
        end
        BODY: begin
          if (head.is_tail) begin
            pkt_inc = 1'b1;
            state_d = HEAD;
          end
        end
        default: state_d = HEAD;
      endcase
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credit_q    <= 1'b0;
      state_q     <= HEAD;
      pkt_count_q <= '0;
    end else begin
      credit_q    <= pop;
      state_q     <= state_d;
      if (pkt_inc) pkt_count_q <= pkt_count_q + 1'b1;
    end
  end

  assign credit_out = credit_q;
  assign pkt_count  = pkt_count_q;

`ifdef NOC_LINK_RX_CHECK_EN
  logic                  overflow_q;
  logic                  dest_chg_q;
  logic [DEST_WIDTH-1:0] head_dest_q;
  logic                  dropped;

  assign dropped = send_in && fifo_full && !pop;

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      dest_chg_q  <= 1'b0;
      head_dest_q <= '0;
    end else begin
      if (dropped) overflow_q <= 1'b1;
      if (pop && state_q == HEAD) head_dest_q <= head.dest;
      if (pop && state_q == BODY && head.dest != head_dest_q) dest_chg_q <= 1'b1;
    end
  end

  assign err_overflow    = overflow_q;
  assign err_dest_change = dest_chg_q;
`else
  logic unused_full;
  assign unused_full     = fifo_full;
  assign err_overflow    = 1'b0;
  assign err_dest_change = 1'b0;
`endif

endmodule

// File: tb/tb_noc_link_rx.sv
// Scoreboard bench for noc_link_rx (BUFFER_DEPTH=2, PKT_CNT_WIDTH=4).
// Expected beats are queued at send time; a negedge monitor checks beats, credits, pkt_count.
module tb_noc_link_rx;

  localparam int FW = 128;
`ifdef NOC_LINK_RX_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          clk_noc = 1'b0;
  logic          rst_n;
  logic [FW-1:0] data_in;
  logic [5:0]    dest_in;
  logic          is_tail_in;
  logic          send_in;
  logic          credit_out;
  logic          axis_out_tvalid;
  logic          axis_out_tready;
  logic [FW-1:0] axis_out_tdata;
  logic          axis_out_tlast;
  logic [1:0]    axis_out_tid;
  logic [3:0]    axis_out_tdest;
  logic [3:0]    pkt_count;
  logic          err_overflow;
  logic          err_dest_change;

  noc_link_rx #(.BUFFER_DEPTH(2), .PKT_CNT_WIDTH(4)) dut (
    .clk_noc         (clk_noc),
    .rst_n           (rst_n),
    .data_in         (data_in),
    .dest_in         (dest_in),
    .is_tail_in      (is_tail_in),
    .send_in         (send_in),
    .credit_out      (credit_out),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tid    (axis_out_tid),
    .axis_out_tdest  (axis_out_tdest),
    .pkt_count       (pkt_count),
    .err_overflow    (err_overflow),
    .err_dest_change (err_dest_change)
  );

  always #5 clk_noc = ~clk_noc;

  int checks = 0;
  int errors = 0;
  int credit_seen = 0;

  // Beat layout: {data, tid, tdest, last}
  logic [FW+6:0] exp_q[$];
  logic          exp_credit = 1'b0;
  logic [3:0]    exp_pkt = 4'd0;

  always @(negedge clk_noc) begin
    logic [FW+6:0] got, e;
    if (!rst_n) begin
      exp_credit = 1'b0;
      exp_pkt    = 4'd0;
    end else begin
      checks++;
      if (credit_out !== exp_credit) begin
        errors++;
        $display("FAIL credit_timing: got %b expected %b at %0t", credit_out, exp_credit, $time);
      end
      if (credit_out === 1'b1) credit_seen++;
      checks++;
      if (pkt_count !== exp_pkt) begin
        errors++;
        $display("FAIL pkt_count_track: got %0d expected %0d at %0t", pkt_count, exp_pkt, $time);
      end
      exp_credit = (axis_out_tvalid === 1'b1) && (axis_out_tready === 1'b1);
      if (exp_credit) begin
        got = {axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tlast};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h tid=%h tdest=%h last=%b, none expected",
                   axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tlast);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL beat: got %h expected %h", got, e);
          end else begin
            $display("beat data=%h tid=%h tdest=%h last=%b", axis_out_tdata,
                     axis_out_tid, axis_out_tdest, axis_out_tlast);
          end
          if (e[0]) exp_pkt = exp_pkt + 4'd1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_noc);
    #1;
  endtask

  // Drives one flit for one cycle; caller sits at posedge+1.
  task automatic send_flit(input logic [FW-1:0] d, input logic [5:0] dst, input logic tail,
                           input bit expect_out);
    data_in    = d;
    dest_in    = dst;
    is_tail_in = tail;
    send_in    = 1'b1;
    if (expect_out) exp_q.push_back({d, dst[5:4], dst[3:0], tail});
    @(posedge clk_noc);
    #1;
    send_in = 1'b0;
  endtask

  task automatic do_reset();
    send_in         = 1'b0;
    axis_out_tready = 1'b0;
    rst_n           = 1'b0;
    idle(2);
    exp_q.delete();
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({axis_out_tvalid, credit_out, pkt_count, err_overflow, err_dest_change} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got tvalid=%b credit=%b pkt=%0d ovf=%b dchg=%b expected all 0",
               axis_out_tvalid, credit_out, pkt_count, err_overflow, err_dest_change);
    end
    do_reset();
  endtask

  task automatic test_single_flit();
    axis_out_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_flit(FW'(128'hA000 + i), 6'h2A, 1'b1, 1'b1);
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: got %0d beats outstanding expected 0", exp_q.size());
    end
    checks++;
    if (pkt_count !== 4'd3) begin
      errors++;
      $display("FAIL single_pkt_count: got %0d expected 3", pkt_count);
    end
  endtask

  task automatic test_backpressure();
    int c0;
    axis_out_tready = 1'b0;
    c0 = credit_seen;
    send_flit(FW'(128'hB0), 6'h15, 1'b1, 1'b1);
    checks++;
    if (axis_out_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL tvalid_latency: got %b expected 1", axis_out_tvalid);
    end
    send_flit(FW'(128'hB1), 6'h15, 1'b1, 1'b1);
    idle(3);
    checks++;
    if (credit_seen != c0) begin
      errors++;
      $display("FAIL bp_no_credit: got %0d credits expected 0", credit_seen - c0);
    end
    axis_out_tready = 1'b1;
    idle(4);
    checks++;
    if (credit_seen - c0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d credits %0d outstanding expected 2 and 0",
               credit_seen - c0, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int c0;
    axis_out_tready = 1'b0;
    c0 = credit_seen;
    send_flit(FW'(128'hC0), 6'h01, 1'b1, 1'b1);
    send_flit(FW'(128'hC1), 6'h02, 1'b1, 1'b1);
    send_flit(FW'(128'hC2), 6'h03, 1'b1, 1'b0);
    idle(1);
    checks++;
    if (err_overflow !== CHECK_EN) begin
      errors++;
      $display("FAIL err_overflow: got %b expected %b", err_overflow, CHECK_EN);
    end
    axis_out_tready = 1'b1;
    idle(5);
    checks++;
    if (credit_seen - c0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_drain: got %0d credits %0d outstanding expected 2 and 0",
               credit_seen - c0, exp_q.size());
    end
    checks++;
    if (err_dest_change !== 1'b0) begin
      errors++;
      $display("FAIL ovf_no_dchg: got %b expected 0", err_dest_change);
    end
  endtask

  task automatic test_dest_change();
    logic [3:0] p0;
    axis_out_tready = 1'b1;
    p0 = pkt_count;
    send_flit(FW'(128'hD0), 6'h2A, 1'b0, 1'b1);
    send_flit(FW'(128'hD1), 6'h2A, 1'b0, 1'b1);
    send_flit(FW'(128'hD2), 6'h2B, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (pkt_count !== p0) begin
      errors++;
      $display("FAIL dchg_mid_count: got %0d expected %0d", pkt_count, p0);
    end
    send_flit(FW'(128'hD3), 6'h2B, 1'b1, 1'b1);
    idle(3);
    checks++;
    if (pkt_count !== p0 + 4'd1) begin
      errors++;
      $display("FAIL dchg_end_count: got %0d expected %0d", pkt_count, p0 + 4'd1);
    end
    checks++;
    if (err_dest_change !== CHECK_EN) begin
      errors++;
      $display("FAIL err_dest_change: got %b expected %b", err_dest_change, CHECK_EN);
    end
  endtask

  task automatic test_pkt_wrap();
    do_reset();
    axis_out_tready = 1'b1;
    for (int i = 0; i < 17; i++) send_flit(FW'($urandom()), 6'($urandom_range(0, 63)), 1'b1, 1'b1);
    idle(4);
    checks++;
    if (pkt_count !== 4'd1) begin
      errors++;
      $display("FAIL pkt_wrap: got %0d expected 1", pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    axis_out_tready = 1'b0;
    send_flit(FW'(128'hE0), 6'h11, 1'b0, 1'b1);
    idle(1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({axis_out_tvalid, credit_out, pkt_count, err_overflow, err_dest_change} !== 8'b0) begin
      errors++;
      $display("FAIL async_reset: got tvalid=%b credit=%b pkt=%0d ovf=%b dchg=%b expected all 0",
               axis_out_tvalid, credit_out, pkt_count, err_overflow, err_dest_change);
    end
    idle(2);
    rst_n = 1'b1;
    c0 = credit_seen;
    axis_out_tready = 1'b1;
    idle(4);
    checks++;
    if (credit_seen != c0 || axis_out_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_credit: got %0d credits tvalid=%b expected 0 and 0",
               credit_seen - c0, axis_out_tvalid);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    send_in         = 1'b0;
    data_in         = '0;
    dest_in         = '0;
    is_tail_in      = 1'b0;
    axis_out_tready = 1'b0;
    idle(1);
    test_reset();
    test_single_flit();
    test_backpressure();
    test_overflow();
    test_dest_change();
    test_pkt_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
